// File: rtl/exit_status_reporter.sv
// Latches the first X-HEEP exit value after reset and reports it once as
// "EXIT xxxxxxxx\r\n" on an 8N1 UART line, then drives pass/fail LEDs.
module exit_status_reporter #(
    parameter int CLK_FREQ_HZ = 20_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        uart_tx_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_led_o,
    output logic        fail_led_o
);

    localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [3:0]    LAST_IDX  = 4'd14;

    if (DIV < 2) begin : g_div_check
        $error("exit_status_reporter: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] value;
        logic        zero;
    } report_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    idx_q, idx_d;
    report_t       rep_q, rep_d;
    logic          valid_q;
    logic          rise;
    logic          baud_end;
    logic [7:0]    tx_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction

    // valid_q clears on reset, so a level held high through reset counts as a rise
    assign rise     = exit_valid_i & ~valid_q;
    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            valid_q <= exit_valid_i;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        if (busy_o) baud_d = baud_end ? '0 : baud_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    rep_d.value = exit_value_i;
                    rep_d.zero  = (exit_value_i == 32'd0);
                    baud_d      = '0;
                    bit_d       = '0;
                    idx_d       = '0;
                    state_d     = TX_START;
                end
            end
            TX_START: begin
                if (baud_end) state_d = TX_DATA;
            end
            TX_DATA: begin
                if (baud_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (baud_end) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = TX_START;
                    end
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
    end

    // Report text: "EXIT ", eight hex digits MSB nibble first, CR, LF
    always_comb begin
        tx_byte = 8'h0A;
        unique case (idx_q)
            4'd0:    tx_byte = 8'h45;
            4'd1:    tx_byte = 8'h58;
            4'd2:    tx_byte = 8'h49;
            4'd3:    tx_byte = 8'h54;
            4'd4:    tx_byte = 8'h20;
            4'd5:    tx_byte = hex_char(rep_q.value[31:28]);
            4'd6:    tx_byte = hex_char(rep_q.value[27:24]);
            4'd7:    tx_byte = hex_char(rep_q.value[23:20]);
            4'd8:    tx_byte = hex_char(rep_q.value[19:16]);
            4'd9:    tx_byte = hex_char(rep_q.value[15:12]);
            4'd10:   tx_byte = hex_char(rep_q.value[11:8]);
            4'd11:   tx_byte = hex_char(rep_q.value[7:4]);
            4'd12:   tx_byte = hex_char(rep_q.value[3:0]);
            4'd13:   tx_byte = 8'h0D;
            default: tx_byte = 8'h0A;
        endcase
    end

    always_comb begin
        uart_tx_o = 1'b1;
        unique case (state_q)
            TX_START: uart_tx_o = 1'b0;
            TX_DATA:  uart_tx_o = tx_byte[bit_q];
            default:  uart_tx_o = 1'b1;
        endcase
    end

    assign busy_o     = (state_q == TX_START) || (state_q == TX_DATA) || (state_q == TX_STOP);
    assign done_o     = (state_q == DONE);
    assign pass_led_o = done_o & rep_q.zero;
    assign fail_led_o = done_o & ~rep_q.zero;

endmodule

// File: tb/tb_exit_status_reporter.sv
// Scoreboard bench: a fast instance (DIV=8) and a default-rate instance (DIV=173),
// each with a UART decoder monitor checked against a text-level report model.
`timescale 1ns/1ps
module tb_exit_status_reporter;

    localparam int DIV_A = 8;
    localparam int DIV_B = 20_000_000 / 115_200;

    typedef struct { logic [7:0] b; longint c; } exp_byte_t;
    typedef struct { longint c; logic pass; } exp_done_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n [2];
    logic        ev    [2];
    logic [31:0] evv   [2];
    logic        tx [2], busy [2], done [2], pass [2], fail [2];

    exp_byte_t eq [2][$];
    exp_done_t dq [2][$];

    int total = 0;
    int bad   = 0;

    exit_status_reporter #(.CLK_FREQ_HZ(8), .BAUD_RATE(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n[0]), .exit_valid_i(ev[0]), .exit_value_i(evv[0]),
        .uart_tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0]),
        .pass_led_o(pass[0]), .fail_led_o(fail[0]));

    exit_status_reporter dut_b (
        .clk_i(clk), .rst_ni(rst_n[1]), .exit_valid_i(ev[1]), .exit_value_i(evv[1]),
        .uart_tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1]),
        .pass_led_o(pass[1]), .fail_led_o(fail[1]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [31:0] v, input int k);
        string hdr;
        string digits;
        hdr    = "EXIT ";
        digits = "0123456789ABCDEF";
        if (k < 5)  return hdr[k];
        if (k < 13) return digits[(v >> (4 * (12 - k))) & 32'hF];
        if (k == 13) return 8'h0D;
        return 8'h0A;
    endfunction

    function automatic int div_of(input int i);
        return (i == 0) ? DIV_A : DIV_B;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input longint c);
        while (cyc < c) step();
    endtask

    task automatic do_reset(input int i);
        rst_n[i] = 1'b0;
        ev[i]    = 1'b0;
        evv[i]   = $urandom;
        repeat (3) step();
        @(negedge clk);
        chk($sformatf("rst%0d_tx", i), tx[i], 1'b1);
        chk($sformatf("rst%0d_flags", i), {busy[i], done[i], pass[i], fail[i]}, 4'b0000);
        step();
        rst_n[i] = 1'b1;
    endtask

    // Drives a rise in the current cycle T and records the expected report.
    task automatic issue(input int i, input logic [31:0] v, output longint t);
        int d;
        d      = div_of(i);
        evv[i] = v;
        ev[i]  = 1'b1;
        t      = cyc;
        for (int k = 0; k < 15; k++) begin
            exp_byte_t e;
            e.b = model_byte(v, k);
            e.c = t + 1 + 10 * k * d;
            eq[i].push_back(e);
        end
        begin
            exp_done_t ed;
            ed.c    = t + 1 + 150 * d;
            ed.pass = (v == 32'd0);
            dq[i].push_back(ed);
        end
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("first%0d_tx_busy", i), {tx[i], busy[i]}, 2'b01);
        evv[i] = $urandom;
    endtask

    task automatic wait_done(input int i, input int lim);
        int n;
        n = 0;
        while (done[i] !== 1'b1 && n < lim) begin
            step();
            n++;
        end
        if (done[i] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done%0d_timeout: done low after %0d cycles, expected high", i, lim);
        end
        repeat (3) step();
        chk($sformatf("queues%0d_drained", i), eq[i].size() + dq[i].size(), 0);
    endtask

    task automatic monitor(input int i);
        int        d;
        bit        active;
        bit        glitch;
        longint    fstart;
        int        fc;
        logic      bitv [10];
        logic [7:0] b;
        logic      prev_done;
        exp_byte_t e;
        exp_done_t ed;
        d         = div_of(i);
        active    = 0;
        glitch    = 0;
        fstart    = 0;
        fc        = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n[i] !== 1'b1) begin
                active    = 0;
                prev_done = 1'b0;
                eq[i].delete();
                dq[i].delete();
            end else begin
                if (!active && tx[i] === 1'b0) begin
                    active = 1;
                    fstart = cyc;
                    fc     = 0;
                    glitch = 0;
                end
                if (active) begin
                    if (fc % d == 0) bitv[fc / d] = tx[i];
                    else if (tx[i] !== bitv[fc / d]) glitch = 1;
                    fc++;
                    if (fc == 10 * d) begin
                        active = 0;
                        for (int k = 0; k < 8; k++) b[k] = bitv[k + 1];
                        if (eq[i].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL byte%0d_unexpected: got 0x%0h at cycle %0d, expected no byte", i, b, fstart);
                        end else begin
                            e = eq[i].pop_front();
                            chk($sformatf("byte%0d_value", i), b, e.b);
                            chk($sformatf("byte%0d_start_cyc", i), fstart, e.c);
                            chk($sformatf("byte%0d_frame", i), {glitch, bitv[0], bitv[9]}, 3'b001);
                        end
                    end
                end
                if (done[i] === 1'b1 && prev_done !== 1'b1) begin
                    if (dq[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL done%0d_unexpected: done rose at cycle %0d, expected none", i, cyc);
                    end else begin
                        ed = dq[i].pop_front();
                        chk($sformatf("done%0d_cyc", i), cyc, ed.c);
                        chk($sformatf("done%0d_leds_busy", i), {pass[i], fail[i], busy[i]},
                            {ed.pass, ~ed.pass, 1'b0});
                    end
                end
                prev_done = done[i];
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        ev[0]    = 1'b0; ev[1]    = 1'b0;
        evv[0]   = '0;   evv[1]   = '0;
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            begin : seq_fast
                longint t;
                logic [31:0] v;
                bit ok;

                // pass and fail reports
                do_reset(0);
                repeat ($urandom_range(1, 10)) step();
                issue(0, 32'h0000_0000, t);
                wait_done(0, 1300);
                do_reset(0);
                step();
                issue(0, 32'hDEAD_BEEF, t);
                wait_done(0, 1300);

                // retrigger during byte 6 and after done must not disturb the first report
                do_reset(0);
                step();
                issue(0, 32'h0000_0000, t);
                goto_cyc(t + 1 + 60 * DIV_A + 10);
                ev[0] = 1'b0; evv[0] = 32'h1234_5678;
                step();
                ev[0] = 1'b1;
                wait_done(0, 1300);
                ev[0] = 1'b0;
                step();
                ev[0] = 1'b1;
                ok = 1;
                repeat (40) begin
                    @(negedge clk);
                    if (tx[0] !== 1'b1 || done[0] !== 1'b1 || pass[0] !== 1'b1 || fail[0] !== 1'b0) ok = 0;
                end
                chk("retrigger_hold", ok, 1'b1);
                step();

                // random values
                for (int r = 0; r < 3; r++) begin
                    do_reset(0);
                    repeat ($urandom_range(1, 20)) step();
                    v = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                    issue(0, v, t);
                    wait_done(0, 1300);
                end

                // reset during byte 3 data, exit_valid held high through reset
                do_reset(0);
                step();
                issue(0, $urandom, t);
                goto_cyc(t + 1 + 30 * DIV_A + DIV_A + 3 * DIV_A + 2);
                @(negedge clk);
                chk("pre_abort_busy", busy[0], 1'b1);
                step();
                rst_n[0] = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("abort_tx_busy", {tx[0], busy[0]}, 2'b10);
                evv[0] = $urandom;
                repeat (2) step();
                @(negedge clk);
                chk("abort_hold_flags", {tx[0], busy[0], done[0]}, 3'b100);
                step();
                rst_n[0] = 1'b1;
                issue(0, $urandom, t);
                wait_done(0, 1300);
            end
            begin : seq_default
                longint t;
                do_reset(1);
                repeat (5) step();
                issue(1, 32'h0000_000A, t);
                wait_done(1, 26500);
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
